// File: rtl/kp_pkg.sv
// rtl/kp_pkg.sv - shared state encodings, constants and helpers for the keypad scanner
package kp_pkg;

    typedef enum logic [2:0] {
        ST_SCAN     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_HELD     = 3'd2,
        ST_RELEASE  = 3'd3
    } kp_state_e;

    localparam logic [3:0] ROWS_RELEASED = 4'b1111;
    localparam logic [3:0] COL_RESET     = 4'b1110;

    // Index of the lowest zero bit; serves both row priority and active-column decode.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (!v[3]) idx = 2'd3;
        if (!v[2]) idx = 2'd2;
        if (!v[1]) idx = 2'd1;
        if (!v[0]) idx = 2'd0;
        return idx;
    endfunction

    function automatic logic [3:0] rotate_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/kp_tick_gen.sv
// rtl/kp_tick_gen.sv - free-running prescaler emitting a one-clk tick every SCAN_DIV cycles
module kp_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        tick    = (count_q == LAST);
        count_d = tick ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/kp_scanner.sv
// rtl/kp_scanner.sv - 4x4 keypad column scanner with press/release debounce
module kp_scanner
    import kp_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DB_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_down,
    output logic [3:0] key_code,
    output logic       key_strobe
);

    localparam int CNT_W = $clog2(DB_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DB_TICKS);

    logic tick;

    kp_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    kp_state_e        state_q, state_d;
    logic [3:0]       rs1_q, rs1_d, rs_q, rs_d;
    logic [3:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_down_q, key_down_d;
    logic             key_strobe_q, key_strobe_d;

    logic             rs_idle;
    logic [3:0]       rs_code;
    logic [CNT_W-1:0] cnt_inc;
    logic             reach;

    always_comb begin
        rs1_d   = row;
        rs_d    = rs1_q;
        rs_idle = (rs_q == ROWS_RELEASED);
        rs_code = {low_index(rs_q), low_index(col_q)};
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        reach   = (cnt_inc >= DB_LIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SCAN;
            rs1_q        <= ROWS_RELEASED;
            rs_q         <= ROWS_RELEASED;
            col_q        <= COL_RESET;
            cnt_q        <= '0;
            cand_q       <= '0;
            key_code_q   <= '0;
            key_down_q   <= 1'b0;
            key_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rs1_q        <= rs1_d;
            rs_q         <= rs_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
            cand_q       <= cand_d;
            key_code_q   <= key_code_d;
            key_down_q   <= key_down_d;
            key_strobe_q <= key_strobe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN: begin
                if (tick && !rs_idle) state_d = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (!rs_idle && rs_code == cand_q) begin
                        if (reach) state_d = ST_HELD;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_HELD: begin
                if (tick && rs_idle) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (tick) begin
                    if (!rs_idle) state_d = ST_HELD;
                    else if (reach) state_d = ST_SCAN;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // Datapath updates; key_strobe self-clears on every non-accepting cycle.
    always_comb begin
        col_d        = col_q;
        cnt_d        = cnt_q;
        cand_d       = cand_q;
        key_code_d   = key_code_q;
        key_down_d   = key_down_q;
        key_strobe_d = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (rs_idle) begin
                        col_d = rotate_col(col_q);
                    end else begin
                        cand_d = rs_code;
                        cnt_d  = CNT_W'(1);
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (!rs_idle && rs_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (reach) begin
                            key_code_d   = cand_q;
                            key_down_d   = 1'b1;
                            key_strobe_d = 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                        col_d = rotate_col(col_q);
                    end
                end
            end
            ST_HELD: begin
                if (tick && rs_idle) cnt_d = CNT_W'(1);
            end
            ST_RELEASE: begin
                if (tick) begin
                    if (!rs_idle) begin
                        cnt_d = '0;
                    end else if (reach) begin
                        cnt_d      = '0;
                        key_down_d = 1'b0;
                        col_d      = rotate_col(col_q);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                cnt_d      = '0;
                key_down_d = 1'b0;
            end
        endcase
    end

    assign col        = col_q;
    assign key_down   = key_down_q;
    assign key_code   = key_code_q;
    assign key_strobe = key_strobe_q;

endmodule

// File: tb/tb_kp_scanner.sv
// tb/tb_kp_scanner.sv - scoreboard bench for kp_scanner with SCAN_DIV=4, DB_TICKS=3
module tb_kp_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DB_TICKS = 3;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_down;
    logic [3:0] key_code;
    logic       key_strobe;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    logic       prev_strobe = 1'b0;

    kp_scanner #(.SCAN_DIV(SCAN_DIV), .DB_TICKS(DB_TICKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_down  (key_down),
        .key_code  (key_code),
        .key_strobe(key_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic n_ticks(input int n);
        repeat (n * SCAN_DIV) @(negedge clk);
    endtask

    // Waits for col to newly switch to c, leaving us at the negedge just after that tick.
    task automatic wait_col(input logic [3:0] c);
        logic [3:0] prev;
        bit found;
        prev  = col;
        found = 0;
        for (int n = 0; n < 64 && !found; n++) begin
            @(negedge clk);
            if (col == c && prev != c) found = 1;
            prev = col;
        end
        if (!found) chk("wait_col_timeout", 32'(col), 32'(c));
    endtask

    task automatic check_restart(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_col_hold"}, 32'(col), 32'(4'b1110));
        @(negedge clk);
        chk({tag, "_col_adv"}, 32'(col), 32'(4'b1101));
    endtask

    // Monitor: every accepted press must match the next expected code and be a single-clk pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_strobe <= 1'b0;
        end else begin
            if (prev_strobe) chk("strobe_one_cycle", 32'(key_strobe), 32'd0);
            if (key_strobe && !prev_strobe) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(key_code), 32'hFFFF);
                end else begin
                    chk("strobe_code", 32'(key_code), 32'(exp_q.pop_front()));
                    chk("strobe_key_down", 32'(key_down), 32'd1);
                end
            end
            prev_strobe <= key_strobe;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        row = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(col), 32'(4'b1110));
        chk("rst_key_down", 32'(key_down), 32'd0);
        chk("rst_key_code", 32'(key_code), 32'd0);
        chk("rst_key_strobe", 32'(key_strobe), 32'd0);
        rst = 1'b0;

        // Idle scanning
        check_restart("idle");
        begin
            logic [3:0] seq [4];
            seq[0] = 4'b1011; seq[1] = 4'b0111; seq[2] = 4'b1110; seq[3] = 4'b1101;
            for (int k = 0; k < 4; k++) begin
                repeat (SCAN_DIV) @(negedge clk);
                chk("idle_col", 32'(col), 32'(seq[k]));
                chk("idle_key_down", 32'(key_down), 32'd0);
            end
        end

        // Row 2 at col 1 -> code 9
        row = 4'b1011;
        exp_q.push_back(4'd9);
        n_ticks(1);
        chk("k9_col_frozen", 32'(col), 32'(4'b1101));
        chk("k9_not_yet", 32'(key_down), 32'd0);
        n_ticks(2);
        chk("k9_key_down", 32'(key_down), 32'd1);
        chk("k9_key_code", 32'(key_code), 32'd9);
        chk("k9_col", 32'(col), 32'(4'b1101));

        // Release bounce: 2 high, 1 low, 3 high
        row = 4'b1111;
        n_ticks(2);
        chk("rel_high2_down", 32'(key_down), 32'd1);
        row = 4'b1011;
        n_ticks(1);
        chk("rel_bounce_down", 32'(key_down), 32'd1);
        row = 4'b1111;
        n_ticks(2);
        chk("rel_high2b_down", 32'(key_down), 32'd1);
        chk("rel_col_held", 32'(col), 32'(4'b1101));
        n_ticks(1);
        chk("rel_done_down", 32'(key_down), 32'd0);
        chk("rel_code_kept", 32'(key_code), 32'd9);
        chk("rel_col_adv", 32'(col), 32'(4'b1011));

        // Short glitch on row 0 at col 1
        wait_col(4'b1101);
        row = 4'b1110;
        n_ticks(1);
        chk("glitch_col_t1", 32'(col), 32'(4'b1101));
        n_ticks(1);
        chk("glitch_col_t2", 32'(col), 32'(4'b1101));
        row = 4'b1111;
        n_ticks(1);
        chk("glitch_col_resume", 32'(col), 32'(4'b1011));
        chk("glitch_key_down", 32'(key_down), 32'd0);
        chk("glitch_code_kept", 32'(key_code), 32'd9);

        // Rows 1 and 3 at col 0 -> lowest row wins, code 4
        wait_col(4'b1110);
        row = 4'b0101;
        exp_q.push_back(4'd4);
        n_ticks(3);
        chk("multi_key_down", 32'(key_down), 32'd1);
        chk("multi_key_code", 32'(key_code), 32'd4);
        chk("multi_col", 32'(col), 32'(4'b1110));
        row = 4'b1111;
        n_ticks(3);
        chk("multi_released", 32'(key_down), 32'd0);
        chk("multi_col_adv", 32'(col), 32'(4'b1101));

        // Reset while HELD on key 15
        wait_col(4'b0111);
        row = 4'b0111;
        exp_q.push_back(4'd15);
        n_ticks(3);
        chk("k15_key_down", 32'(key_down), 32'd1);
        chk("k15_key_code", 32'(key_code), 32'd15);
        #1 rst = 1'b1;
        #1;
        chk("hrst_col", 32'(col), 32'(4'b1110));
        chk("hrst_key_down", 32'(key_down), 32'd0);
        chk("hrst_key_strobe", 32'(key_strobe), 32'd0);
        chk("hrst_key_code", 32'(key_code), 32'd0);
        repeat (2) @(negedge clk);
        row = 4'b1111;
        rst = 1'b0;
        check_restart("hrst");
        chk("hrst_idle_down", 32'(key_down), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
